adc_dac_bridge: RTL
===================

# adc_dac_bridge

Parametrised multi-channel ADC-to-DAC sample bridge with triggered capture. Sits between the ADC sampling front end and the DAC drivers in `adc_clk` domain. Each channel is registered, format-converted from offset-binary or two's complement, optionally inverted, and width-mapped to the DAC in sign-extend or left-justify mode. A trigger state machine records a fixed-length window of one selected channel into an external capture RAM for debug readout.

## Interface
Parameters:
- `NCH`, 2, channel count (1..8)
- `ADC_W`, 12, ADC sample width
- `DAC_W`, 14, DAC word width; elaboration error if `DAC_W < ADC_W`
- `CAP_AW`, 11, capture address width; window = 2^CAP_AW samples
- `CH_W`, `max(1,$clog2(NCH))`, channel-select width (derived)

Ports:
- `adc_clk` in 1 — sole clock
- `rst_n` in 1 — asynchronous, active-low reset
- `adc_data` in NCH*ADC_W — raw samples, channel k at bits [k*ADC_W +: ADC_W]
- `adc_fmt` in 1 — 0 two's complement, 1 offset binary
- `dac_mode` in 1 — 0 sign-extend (LSB-aligned), 1 left-justify (zero LSBs)
- `ch_inv` in NCH — per-channel invert request
- `dac_data` out NCH*DAC_W — DAC words, same packing
- `dac_valid` out 1 — pipeline filled
- `cap_arm` in 1 — arm/re-arm pulse
- `cap_ch` in CH_W — capture/trigger channel
- `cap_lvl` in ADC_W — signed trigger level
- `cap_state` out 2 — 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- `cap_wr` out 1, `cap_addr` out CAP_AW, `cap_data` out ADC_W — capture RAM write port
- `cap_done` out 1 — high in DONE

## Operation
- S1: register `adc_data`. S2: convert to signed (offset binary: invert MSB); apply inversion if enabled. S3: width map, register to `dac_data`.
- Inversion saturates: -2^(ADC_W-1) maps to 2^(ADC_W-1)-1.
- Sign-extend: replicate bit ADC_W-1 into upper DAC_W-ADC_W bits. Left-justify: sample in MSBs, zeros below.
- `adc_fmt`, `dac_mode`, `ch_inv` sampled each cycle; changes affect samples entering S2/S3 that cycle, no flush.
- FSM: IDLE --cap_arm--> ARMED (clear addr, clear prev_valid). ARMED: rising crossing on S2 sample of `cap_ch` (prev_valid && prev < cap_lvl && cur >= cap_lvl, signed) --> CAPTURE. CAPTURE: one write per cycle, addr 0..2^CAP_AW-1; after last write --> DONE. DONE --cap_arm--> ARMED.
- First sample after arming only loads prev; cannot trigger.
- `cap_arm` in ARMED or CAPTURE ignored. `cap_ch`/`cap_lvl` sampled continuously; changing mid-capture has no effect on the running window's channel — channel latched on trigger.
- Captured data = S2 signed sample (post-conversion, post-inversion); first write is the trigger sample.

## Timing
- Reset: all pipeline registers 0, `dac_data` 0, `dac_valid` 0, `cap_state` IDLE, `cap_wr` 0, `cap_addr` 0, `cap_data` 0, `cap_done` 0.
- `adc_data` at edge t appears on `dac_data` after edge t+3 (3-cycle latency, independent of macro).
- `dac_valid` rises after the 3rd edge following reset release; stays 1.
- Trigger sample in S2 at cycle t: `cap_wr`=1, `cap_addr`=0 registered at t+1; `cap_wr` held continuously for 2^CAP_AW cycles; `cap_state`=DONE and `cap_done`=1 the cycle after last write.
- `rst_n` low mid-capture: immediate return to IDLE, `cap_wr` deasserted asynchronously.

## Configuration
- `ADC_DAC_BRIDGE_INVERT_EN` defined: `ch_inv` honoured with saturating inversion.
- Undefined: `ch_inv` ignored, no negation logic; S2 register retained so latency stays 3.

## Structure
- Shared package `adc_dac_pkg`: FSM state enum (`CAP_IDLE`, `CAP_ARMED`, `CAP_CAPTURE`, `CAP_DONE`), `FMT_TWOS`/`FMT_OFFSET`, `MODE_SEXT`/`MODE_LJUST` constants.
- One sub-module `adc_dac_chan`: per-channel S1–S3 pipeline, instantiated NCH times via generate; FSM in top.

## Test plan
- Offset binary, ADC_W=12, DAC_W=14, sign-extend: input 0x000 -> 0x3800 after 3 cycles; 0xFFF -> 0x07FF.
- Two's complement, left-justify: input 0x801 -> 0x2004; 0x7FF -> 0x1FFC.
- Inversion (macro on), ch_inv[0]=1: 0x800 -> 0x7FF saturated, 0x001 -> 0xFFF; ch1 unaffected; macro off -> unchanged.
- Capture, CAP_AW=4, cap_lvl=0, ramp -8..+7 on ch1: trigger on sample 0, 16 writes data 0,1,..., cap_done after 16 cycles; cap_arm during CAPTURE ignored.
- Arm with first post-arm sample already above level: no trigger until a genuine rising crossing.
- rst_n low at write 5 of capture: cap_wr=0 immediately, state IDLE, dac_valid=0, refill latency 3.

Source files
------------

// File: rtl/adc_dac_pkg.sv
// ----------------------------------------------------------------------------
// adc_dac_pkg
// Shared definitions for the ADC-to-DAC sample bridge.
//   cap_state_t          : capture state machine encoding (also the value
//                          presented on the cap_state output)
//   FMT_TWOS/FMT_OFFSET  : adc_fmt input encodings
//   MODE_SEXT/MODE_LJUST : dac_mode input encodings
// ----------------------------------------------------------------------------
package adc_dac_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    localparam logic FMT_TWOS   = 1'b0;
    localparam logic FMT_OFFSET = 1'b1;

    localparam logic MODE_SEXT  = 1'b0;
    localparam logic MODE_LJUST = 1'b1;

endpackage

// File: rtl/adc_dac_chan.sv
// ----------------------------------------------------------------------------
// adc_dac_chan
// One channel of the bridge datapath, three register stages:
//   S1 : raw ADC sample register
//   S2 : signed sample (format converted, optionally inverted)
//   S3 : DAC word (sign-extended or left-justified)
// Optional feature macro: ADC_DAC_BRIDGE_INVERT_EN
//   defined   -> 'inv' negates the S2 sample with saturation
//   undefined -> 'inv' is ignored; S2 is still a register so latency is 3
// Ports:
//   adc_clk, rst_n : clock, asynchronous active-low reset
//   sample_in      : raw ADC sample
//   adc_fmt        : 0 two's complement, 1 offset binary
//   dac_mode       : 0 sign-extend, 1 left-justify
//   inv            : invert request for this channel
//   s2_sample      : S2 register contents (feeds the capture logic)
//   dac_word       : S3 register contents
// ----------------------------------------------------------------------------
module adc_dac_chan
    import adc_dac_pkg::*;
#(
    parameter int ADC_W = 12,
    parameter int DAC_W = 14
) (
    input  logic                    adc_clk,
    input  logic                    rst_n,
    input  logic [ADC_W-1:0]        sample_in,
    input  logic                    adc_fmt,
    input  logic                    dac_mode,
    input  logic                    inv,
    output logic signed [ADC_W-1:0] s2_sample,
    output logic [DAC_W-1:0]        dac_word
);

    localparam logic [ADC_W-1:0] MSB_MASK = ADC_W'(1) << (ADC_W - 1);
    localparam int               SHIFT    = DAC_W - ADC_W;

    logic [ADC_W-1:0]        s1;
    logic signed [ADC_W-1:0] conv;
    logic signed [ADC_W-1:0] s2_nxt;
    logic [DAC_W-1:0]        dac_nxt;

    // Offset binary becomes two's complement by flipping the MSB.
    always_comb begin
        conv = (adc_fmt == FMT_OFFSET) ? $signed(s1 ^ MSB_MASK) : $signed(s1);
    end

`ifdef ADC_DAC_BRIDGE_INVERT_EN
    localparam logic signed [ADC_W-1:0] SAT_MIN = MSB_MASK;
    localparam logic signed [ADC_W-1:0] SAT_MAX = ~MSB_MASK;

    // The most negative code has no positive counterpart, so it clamps to
    // the largest positive code instead of wrapping back onto itself.
    always_comb begin
        s2_nxt = conv;
        if (inv) begin
            s2_nxt = (conv == SAT_MIN) ? SAT_MAX : -conv;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv;

    always_comb begin
        s2_nxt = conv;
    end
`endif

    // Size-casting a signed value sign-extends; the left-justify path casts
    // the raw bits unsigned first so the shift fills the LSBs with zeros.
    always_comb begin
        if (dac_mode == MODE_LJUST) begin
            dac_nxt = DAC_W'($unsigned(s2_sample)) << SHIFT;
        end else begin
            dac_nxt = DAC_W'(s2_sample);
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2_sample <= '0;
            dac_word  <= '0;
        end else begin
            s1        <= sample_in;
            s2_sample <= s2_nxt;
            dac_word  <= dac_nxt;
        end
    end

endmodule

// File: rtl/adc_dac_bridge.sv
// ----------------------------------------------------------------------------
// adc_dac_bridge
// Multi-channel ADC-to-DAC sample bridge with a triggered debug capture of
// one channel into an external RAM.
// Optional feature macro: ADC_DAC_BRIDGE_INVERT_EN (per-channel saturating
// inversion via ch_inv; ignored when undefined).
// Ports:
//   adc_clk, rst_n     : sole clock, asynchronous active-low reset
//   adc_data           : NCH packed raw samples, channel k at [k*ADC_W +: ADC_W]
//   adc_fmt, dac_mode  : input format / DAC width-mapping selects
//   ch_inv             : per-channel invert requests
//   dac_data           : NCH packed DAC words, dac_valid once the pipe is full
//   cap_arm            : arm / re-arm pulse (ignored while ARMED or CAPTURE)
//   cap_ch, cap_lvl    : trigger channel and signed trigger level
//   cap_state          : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   cap_wr/addr/data   : capture RAM write port
//   cap_done           : high in DONE
// ----------------------------------------------------------------------------
module adc_dac_bridge
    import adc_dac_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADC_W  = 12,
    parameter int DAC_W  = 14,
    parameter int CAP_AW = 11,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   adc_clk,
    input  logic                   rst_n,
    input  logic [NCH*ADC_W-1:0]   adc_data,
    input  logic                   adc_fmt,
    input  logic                   dac_mode,
    input  logic [NCH-1:0]         ch_inv,
    output logic [NCH*DAC_W-1:0]   dac_data,
    output logic                   dac_valid,
    input  logic                   cap_arm,
    input  logic [CH_W-1:0]        cap_ch,
    input  logic [ADC_W-1:0]       cap_lvl,
    output logic [1:0]             cap_state,
    output logic                   cap_wr,
    output logic [CAP_AW-1:0]      cap_addr,
    output logic [ADC_W-1:0]       cap_data,
    output logic                   cap_done
);

    if (DAC_W < ADC_W) begin : g_bad_width
        $error("adc_dac_bridge: DAC_W must not be smaller than ADC_W");
    end
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("adc_dac_bridge: NCH must be in 1..8");
    end
    if (ADC_W < 2) begin : g_bad_adc_w
        $error("adc_dac_bridge: ADC_W must be at least 2");
    end

    localparam logic [CAP_AW-1:0] LAST_ADDR = '1;

    logic signed [ADC_W-1:0] s2_arr [NCH];

    logic [1:0]              fill_cnt;
    cap_state_t              state, state_nxt;
    logic [CH_W-1:0]         sel;
    logic [CH_W-1:0]         ch_lat, ch_lat_nxt;
    logic signed [ADC_W-1:0] cur;
    logic signed [ADC_W-1:0] lat_sample;
    logic signed [ADC_W-1:0] prev, prev_nxt;
    logic                    prev_valid, prev_valid_nxt;
    logic                    trig;
    logic                    wr_nxt;
    logic [CAP_AW-1:0]       addr_nxt;
    logic [ADC_W-1:0]        data_nxt;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        adc_dac_chan #(
            .ADC_W (ADC_W),
            .DAC_W (DAC_W)
        ) u_chan (
            .adc_clk   (adc_clk),
            .rst_n     (rst_n),
            .sample_in (adc_data[k*ADC_W +: ADC_W]),
            .adc_fmt   (adc_fmt),
            .dac_mode  (dac_mode),
            .inv       (ch_inv[k]),
            .s2_sample (s2_arr[k]),
            .dac_word  (dac_data[k*DAC_W +: DAC_W])
        );
    end

    // Fill counter: dac_valid rises on the third edge after reset release,
    // when the first real sample has passed all three stages.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt  <= 2'd0;
            dac_valid <= 1'b0;
        end else if (!dac_valid) begin
            if (fill_cnt == 2'd2) begin
                dac_valid <= 1'b1;
            end else begin
                fill_cnt <= fill_cnt + 2'd1;
            end
        end
    end

    // Out-of-range channel selects (NCH not a power of two) fall back to
    // channel 0 so the array index stays legal.
    always_comb begin
        sel        = (int'(cap_ch) < NCH) ? cap_ch : '0;
        cur        = s2_arr[sel];
        lat_sample = s2_arr[ch_lat];
        trig       = prev_valid && (prev < $signed(cap_lvl))
                                && (cur >= $signed(cap_lvl));
    end

    // State register plus the registered capture-port signals.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CAP_IDLE;
            cap_wr     <= 1'b0;
            cap_addr   <= '0;
            cap_data   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            ch_lat     <= '0;
        end else begin
            state      <= state_nxt;
            cap_wr     <= wr_nxt;
            cap_addr   <= addr_nxt;
            cap_data   <= data_nxt;
            prev       <= prev_nxt;
            prev_valid <= prev_valid_nxt;
            ch_lat     <= ch_lat_nxt;
        end
    end

    // Next-state logic. CAPTURE ends once the write to the last address is
    // on the port; arming is only accepted from IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            CAP_IDLE:    if (cap_arm) state_nxt = CAP_ARMED;
            CAP_ARMED:   if (trig) state_nxt = CAP_CAPTURE;
            CAP_CAPTURE: if (cap_addr == LAST_ADDR) state_nxt = CAP_DONE;
            CAP_DONE:    if (cap_arm) state_nxt = CAP_ARMED;
            default:     state_nxt = CAP_IDLE;
        endcase
    end

    // Output/datapath logic. While ARMED, prev tracks the selected channel
    // so the first sample after arming can only seed prev. The trigger
    // sample is the first write and the channel is latched at that point.
    always_comb begin
        wr_nxt         = 1'b0;
        addr_nxt       = cap_addr;
        data_nxt       = cap_data;
        prev_nxt       = prev;
        prev_valid_nxt = prev_valid;
        ch_lat_nxt     = ch_lat;
        case (state)
            CAP_IDLE, CAP_DONE: begin
                if (cap_arm) begin
                    addr_nxt       = '0;
                    prev_valid_nxt = 1'b0;
                end
            end
            CAP_ARMED: begin
                prev_nxt       = cur;
                prev_valid_nxt = 1'b1;
                if (trig) begin
                    wr_nxt     = 1'b1;
                    addr_nxt   = '0;
                    data_nxt   = cur;
                    ch_lat_nxt = sel;
                end
            end
            CAP_CAPTURE: begin
                if (cap_addr != LAST_ADDR) begin
                    wr_nxt   = 1'b1;
                    addr_nxt = cap_addr + 1'b1;
                    data_nxt = lat_sample;
                end
            end
            default: ;
        endcase
    end

    assign cap_state = state;
    assign cap_done  = (state == CAP_DONE);

endmodule
